// File: rtl/uart_pkg.sv
// Shared definitions for the UART bridge: FSM encodings, RX FIFO entry
// format and the default transmit-status wait limit.
package uart_pkg;

   // Default number of cycles to wait on TBRE / TSRE before giving up.
   localparam int TIMEOUT_DEFAULT = 65535;

   // Width of the TBRE / TSRE wait counter.
   localparam int CNT_W = 16;

   // Bridge FSM encodings. Four bits leave spare codes, which are treated
   // as illegal and steer the FSM back to IDLE.
   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RD_STROBE  = 4'd1,
      RD_CAPTURE = 4'd2,
      WR_SETUP   = 4'd3,
      WR_PULSE   = 4'd4,
      WR_HOLD    = 4'd5,
      WR_TBRE    = 4'd6,
      WR_TSRE    = 4'd7
   } state_t;

   // One RX FIFO entry: error flag above the received byte (9 bits).
   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } rx_entry_t;

   // True in the three states where the bridge owns the shared data bus.
   function automatic logic is_drive_state(input state_t s);
      return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received UART bytes with their
// error flag. A push and a pop in the same cycle both happen, even when
// the FIFO is full.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int RX_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  rx_entry_t push_data,
   input  logic      pop,
   output rx_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(RX_DEPTH);
   localparam int CW = AW + 1;

   rx_entry_t        mem [RX_DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(RX_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg];

   // Storage array: written on an accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_bridge.sv
// Bridge between internal valid/ready byte streams and the board UART chip
// that shares the 8-bit RAM data bus. Reads are serviced ahead of writes and
// land in an RX FIFO; writes generate a setup/pulse/hold strobe and then
// wait (bounded) for the chip's transmit-empty flags.
module uart_bridge
   import uart_pkg::*;
#(
   parameter int RX_DEPTH = 4,
   parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire  [7:0] baseram_data,
   output logic       baseram_oe,
   output logic       baseram_ce,
   output logic       baseram_we,
   output logic       uart_wrn,
   output logic       uart_rdn,
   input  logic       uart_tbre,
   input  logic       uart_tsre,
   input  logic       uart_data_ready,
   input  logic       uart_framing_error,
   input  logic       uart_parity_error,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_err,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       tx_timeout
);

   state_t           state_reg;
   state_t           state_next;
   logic             rdn_reg;
   logic             rdn_next;
   logic             wrn_reg;
   logic             wrn_next;
   logic             drive_reg;
   logic             drive_next;
   logic             ready_en_reg;
   logic             timeout_reg;
   logic             timeout_hit;
   logic [7:0]       tx_byte_reg;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             wait_done;
   logic             read_go;
   logic             tx_fire;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   rx_entry_t        push_entry;
   rx_entry_t        head_entry;

   // RAM stays deselected; the bus is shared with the UART only.
   assign baseram_oe = 1'b1;
   assign baseram_ce = 1'b1;
   assign baseram_we = 1'b1;

   assign baseram_data = drive_reg ? tx_byte_reg : 8'hzz;
   assign uart_rdn     = rdn_reg;
   assign uart_wrn     = wrn_reg;
   assign tx_timeout   = timeout_reg;

   // A read is only started when the FIFO can take the byte; otherwise the
   // chip keeps holding it.
   assign read_go   = uart_data_ready && !fifo_full;
   assign tx_fire   = tx_valid && tx_ready;
   assign wait_done = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

   // State register plus registered strobes, bus enable and bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         rdn_reg      <= 1'b1;
         wrn_reg      <= 1'b1;
         drive_reg    <= 1'b0;
         ready_en_reg <= 1'b0;
         timeout_reg  <= 1'b0;
         tx_byte_reg  <= '0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rdn_reg      <= rdn_next;
         wrn_reg      <= wrn_next;
         drive_reg    <= drive_next;
         ready_en_reg <= 1'b1;
         if (timeout_hit) begin
            timeout_reg <= 1'b1;
         end
         if (tx_fire) begin
            tx_byte_reg <= tx_data;
         end
         wait_cnt_reg <= (state_next != state_reg) ? '0 : wait_cnt_reg + CNT_W'(1);
      end
   end

   // Next-state logic; unknown encodings fall back to IDLE.
   always_comb begin
      state_next  = IDLE;
      timeout_hit = 1'b0;
      case (state_reg)
         IDLE: begin
            if (read_go) begin
               state_next = RD_STROBE;
            end else if (tx_fire) begin
               state_next = WR_SETUP;
            end else begin
               state_next = IDLE;
            end
         end
         RD_STROBE:  state_next = RD_CAPTURE;
         RD_CAPTURE: state_next = IDLE;
         WR_SETUP:   state_next = WR_PULSE;
         WR_PULSE:   state_next = WR_HOLD;
         WR_HOLD:    state_next = WR_TBRE;
         WR_TBRE: begin
            if (uart_tbre) begin
               state_next = WR_TSRE;
            end else if (wait_done) begin
               state_next  = IDLE;
               timeout_hit = 1'b1;
            end else begin
               state_next = WR_TBRE;
            end
         end
         WR_TSRE: begin
            if (uart_tsre) begin
               state_next = IDLE;
            end else if (wait_done) begin
               state_next  = IDLE;
               timeout_hit = 1'b1;
            end else begin
               state_next = WR_TSRE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: handshake, FIFO push, and next values of the registered strobes.
   always_comb begin
      tx_ready   = ready_en_reg && (state_reg == IDLE) && !read_go;
      fifo_push  = (state_reg == RD_CAPTURE);
      rdn_next   = !((state_next == RD_STROBE) || (state_next == RD_CAPTURE));
      wrn_next   = (state_next != WR_PULSE);
      drive_next = is_drive_state(state_next);
   end

   assign push_entry = '{err: uart_framing_error | uart_parity_error, data: baseram_data};

   uart_rx_fifo #(
      .RX_DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (rx_ready),
      .head      (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rx_valid = !fifo_empty;
   assign rx_data  = head_entry.data;
   assign rx_err   = head_entry.err;

endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge with a behavioural UART chip model and
// RX/TX scoreboards.
module tb_uart_bridge;

   logic       clk = 1'b0;
   logic       rst;
   wire  [7:0] baseram_data;
   logic       baseram_oe, baseram_ce, baseram_we;
   logic       uart_wrn, uart_rdn;
   logic       uart_tbre, uart_tsre;
   logic       uart_data_ready = 1'b0;
   logic       uart_framing_error, uart_parity_error;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_err, rx_valid, rx_ready, tx_timeout;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] exp_rx[$];
   logic [7:0] exp_tx[$];

   // Chip receive side: queued bytes, head byte on the bus while RDn is low.
   logic [8:0] chip_q[$];
   logic [7:0] chip_head = 8'h00;
   logic       chip_err  = 1'b0;
   logic       rdn_prev  = 1'b1;
   int         chip_pops = 0;

   always #5 clk = ~clk;

   assign baseram_data       = (uart_rdn === 1'b0) ? chip_head : 8'hzz;
   assign uart_framing_error = chip_err;
   assign uart_parity_error  = 1'b0;

   // Chip model: a completed read (RDn rising) retires the head byte at once;
   // new bytes are noticed just after each falling clock edge.
   always begin
      @(negedge clk or posedge uart_rdn);
      if (clk === 1'b0) #1;
      if (rdn_prev === 1'b0 && uart_rdn === 1'b1 && chip_q.size() > 0) begin
         void'(chip_q.pop_front());
         chip_pops++;
      end
      rdn_prev        = uart_rdn;
      uart_data_ready = (chip_q.size() > 0);
      chip_head       = (chip_q.size() > 0) ? chip_q[0][7:0] : 8'h00;
      chip_err        = (chip_q.size() > 0) ? chip_q[0][8] : 1'b0;
   end

   uart_bridge #(
      .RX_DEPTH (4),
      .TIMEOUT  (16)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .baseram_data       (baseram_data),
      .baseram_oe         (baseram_oe),
      .baseram_ce         (baseram_ce),
      .baseram_we         (baseram_we),
      .uart_wrn           (uart_wrn),
      .uart_rdn           (uart_rdn),
      .uart_tbre          (uart_tbre),
      .uart_tsre          (uart_tsre),
      .uart_data_ready    (uart_data_ready),
      .uart_framing_error (uart_framing_error),
      .uart_parity_error  (uart_parity_error),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .rx_data            (rx_data),
      .rx_err             (rx_err),
      .rx_valid           (rx_valid),
      .rx_ready           (rx_ready),
      .tx_timeout         (tx_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chip_send(input logic err, input logic [7:0] b);
      chip_q.push_back({err, b});
      exp_rx.push_back({err, b});
   endtask

   // Wait (bounded) for a head entry, compare it with the scoreboard, pop it.
   task automatic pop_rx(input string tag);
      logic [8:0] e;
      int w;
      w = 0;
      while (rx_valid !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
      e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 9'h000;
      chk({tag, "_data"}, {23'd0, rx_err, rx_data}, {23'd0, e});
      $display("rx %s: err=%0b data=%02h", tag, rx_err, rx_data);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   // Offer one byte, then watch the write cycle. i=0 is the first cycle after
   // the handshake edge; TBRE/TSRE rise at the given cycle (-1 = never).
   task automatic do_tx(input logic [7:0] d, input int tbre_at, input int tsre_at,
                        output int ready_at, output int drv, output int wlo);
      int w;
      logic [7:0] e;
      exp_tx.push_back(d);
      uart_tbre = 1'b0;
      uart_tsre = 1'b0;
      tx_data   = d;
      tx_valid  = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("tx_handshake_wait", {31'd0, (w < 50)}, 32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      ready_at = -1;
      drv      = 0;
      wlo      = 0;
      for (int i = 0; i < 60; i++) begin
         if (i == tbre_at) uart_tbre = 1'b1;
         if (i == tsre_at) uart_tsre = 1'b1;
         if (baseram_data === d) drv++;
         if (uart_wrn === 1'b0) begin
            wlo++;
            e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
            chk("tx_bus_at_wrn", {24'd0, baseram_data}, {24'd0, e});
         end
         if (tx_ready === 1'b1) begin
            ready_at = i;
            break;
         end
         @(negedge clk);
      end
      $display("tx %02h: ready_at=%0d bus_cycles=%0d wrn_low=%0d timeout=%0b",
               d, ready_at, drv, wlo, tx_timeout);
   endtask

   initial begin
      int ra, dv, wl, p0, lo, w;
      rst       = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      rx_ready  = 1'b0;
      uart_tbre = 1'b0;
      uart_tsre = 1'b0;

      // Reset state
      cycles(3);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_wrn", {31'd0, uart_wrn}, 32'd1);
      chk("rst_rdn", {31'd0, uart_rdn}, 32'd1);
      chk("rst_timeout", {31'd0, tx_timeout}, 32'd0);
      chk("ram_deselect", {29'd0, baseram_oe, baseram_ce, baseram_we}, 32'd7);
      rst = 1'b1;
      chk("ready_before_edge", {31'd0, tx_ready}, 32'd0);
      @(negedge clk);
      chk("ready_after_edge", {31'd0, tx_ready}, 32'd1);

      // Single read of 0x41: RDn low two cycles, data valid the cycle after.
      chip_send(1'b0, 8'h41);
      lo = 0;
      w  = 0;
      while (rx_valid !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
         if (uart_rdn === 1'b0) lo++;
      end
      chk("rd_rdn_low_cycles", lo, 32'd2);
      chk("rd_valid_latency", w, 32'd3);
      pop_rx("rx41");

      // Write 0x5A, TBRE after 10 cycles, TSRE 5 later.
      do_tx(8'h5A, 10, 15, ra, dv, wl);
      chk("tx5a_ready_at", ra, 32'd16);
      chk("tx5a_bus_cycles", dv, 32'd3);
      chk("tx5a_wrn_low", wl, 32'd1);
      chk("tx5a_timeout", {31'd0, tx_timeout}, 32'd0);

      // Five bytes with no consumer: four stored, fifth held by the chip.
      p0 = chip_pops;
      for (int k = 0; k < 5; k++) begin
         chip_send(k == 2, 8'h60 + 8'(k));
      end
      cycles(40);
      chk("full_reads", chip_pops - p0, 32'd4);
      chk("full_rdn_idle", {31'd0, uart_rdn}, 32'd1);
      chk("full_chip_left", chip_q.size(), 32'd1);
      pop_rx("rx_full0");
      cycles(10);
      chk("full_fifth_read", chip_pops - p0, 32'd5);
      for (int k = 1; k < 5; k++) begin
         pop_rx("rx_full");
      end

      // Read and write requested together: read first, framing error kept.
      chip_send(1'b1, 8'h33);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      @(negedge clk);
      chk("prio_rdn", {31'd0, uart_rdn}, 32'd0);
      chk("prio_tx_ready", {31'd0, tx_ready}, 32'd0);
      chk("prio_wrn", {31'd0, uart_wrn}, 32'd1);
      do_tx(8'hC3, 4, 6, ra, dv, wl);
      chk("txc3_ready_at", ra, 32'd7);
      chk("txc3_bus_cycles", dv, 32'd3);
      chk("txc3_wrn_low", wl, 32'd1);
      pop_rx("rx_ferr");

      // TBRE never arrives: timeout after 16 wait cycles.
      do_tx(8'h3C, -1, -1, ra, dv, wl);
      chk("to_ready_at", ra, 32'd19);
      chk("to_flag", {31'd0, tx_timeout}, 32'd1);
      chk("to_wrn_low", wl, 32'd1);

      // Flag is sticky across a later good write.
      do_tx(8'h96, 4, 6, ra, dv, wl);
      chk("sticky_ready_at", ra, 32'd7);
      chk("sticky_flag", {31'd0, tx_timeout}, 32'd1);

      // Reset asserted during the write pulse.
      uart_tbre = 1'b0;
      uart_tsre = 1'b0;
      tx_data   = 8'hA5;
      tx_valid  = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      chk("abort_setup_bus", {24'd0, baseram_data}, 32'h0000_00A5);
      @(negedge clk);
      chk("abort_pulse_wrn", {31'd0, uart_wrn}, 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("abort_wrn", {31'd0, uart_wrn}, 32'd1);
      chk("abort_rdn", {31'd0, uart_rdn}, 32'd1);
      chk("abort_bus_released", {31'd0, (baseram_data !== 8'hA5)}, 32'd1);
      chk("abort_tx_ready", {31'd0, tx_ready}, 32'd0);
      chk("abort_timeout_clr", {31'd0, tx_timeout}, 32'd0);
      $display("reset during write pulse: wrn=%0b rdn=%0b", uart_wrn, uart_rdn);
      @(negedge clk);
      rst = 1'b1;
      chk("rerst_ready_before", {31'd0, tx_ready}, 32'd0);
      @(negedge clk);
      chk("rerst_ready_after", {31'd0, tx_ready}, 32'd1);
      chk("rerst_no_write", {31'd0, uart_wrn}, 32'd1);

      // Bridge still works after the abort.
      chip_send(1'b0, 8'h7E);
      pop_rx("rx_post_rst");

      chk("rx_sb_drained", exp_rx.size(), 32'd0);
      chk("tx_sb_drained", exp_tx.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
